// File: rtl/path_writeback.sv
// path_writeback: after the solver finishes, streams each node's (prev, distance)
// pair out to memory as two consecutive word writes from a latched base address.
`ifndef DEFAULT_MAX_NODES
`define DEFAULT_MAX_NODES 8
`endif
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 4
`endif
`ifndef DEFAULT_VALUE_WIDTH
`define DEFAULT_VALUE_WIDTH 16
`endif
`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 16
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 32
`endif

module path_writeback #(
   parameter int MAX_NODES   = `DEFAULT_MAX_NODES,
   parameter int INDEX_WIDTH = `DEFAULT_INDEX_WIDTH,
   parameter int VALUE_WIDTH = `DEFAULT_VALUE_WIDTH,
   parameter int MADDR_WIDTH = `DEFAULT_MADDR_WIDTH,
   parameter int MDATA_WIDTH = `DEFAULT_MDATA_WIDTH
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           start,
   input  logic [INDEX_WIDTH-1:0]         number_of_nodes,
   input  logic [MADDR_WIDTH-1:0]         base_address,
   input  logic [INDEX_WIDTH*MAX_NODES-1:0] prev_vector_flattened,
   input  logic [VALUE_WIDTH*MAX_NODES-1:0] distance_vector_flattened,
   output logic                           mem_write_enable,
   input  logic                           mem_write_ready,
   output logic [MADDR_WIDTH-1:0]         mem_addr,
   output logic [MDATA_WIDTH-1:0]         mem_write_data,
   output logic                           busy,
   output logic                           done
);

   typedef enum logic [1:0] {
      IDLE,
      WRITE_PREV,
      WRITE_DIST,
      DONE
   } state_t;

   state_t                 state;
   state_t                 next_state;
   logic [INDEX_WIDTH-1:0] node_index;
   logic [INDEX_WIDTH-1:0] node_count;
   logic [INDEX_WIDTH-1:0] effective_count;
   logic [MADDR_WIDTH-1:0] base_reg;
   logic [MADDR_WIDTH:0]   double_index;
   logic [MADDR_WIDTH-1:0] prev_addr;
   logic [INDEX_WIDTH-1:0] prev_sel;
   logic [VALUE_WIDTH-1:0] dist_sel;
   logic                   last_node;

   // Requests beyond the vector capacity are clamped to MAX_NODES.
   always_comb begin
      effective_count = number_of_nodes;
      if (32'(number_of_nodes) > MAX_NODES) begin
         effective_count = INDEX_WIDTH'(MAX_NODES);
      end
   end

   assign double_index = (MADDR_WIDTH+1)'(node_index) << 1;
   assign prev_addr    = base_reg + double_index[MADDR_WIDTH-1:0];
   assign last_node    = (node_index == node_count - 1'b1);

   // Vectors are read live; the producer holds them stable while busy.
   always_comb begin
      prev_sel = '0;
      dist_sel = '0;
      for (int j = 0; j < MAX_NODES; j++) begin
         if (32'(node_index) == j) begin
            prev_sel = prev_vector_flattened[INDEX_WIDTH*j +: INDEX_WIDTH];
            dist_sel = distance_vector_flattened[VALUE_WIDTH*j +: VALUE_WIDTH];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         node_index <= '0;
         node_count <= '0;
         base_reg   <= '0;
      end else begin
         state <= next_state;
         if (state == IDLE && start) begin
            node_count <= effective_count;
            base_reg   <= base_address;
            node_index <= '0;
         end else if (state == WRITE_DIST && mem_write_ready && !last_node) begin
            node_index <= node_index + 1'b1;
         end
      end
   end

   // Outputs are decoded from state, so enable and address/data hold until accepted.
   always_comb begin
      next_state       = state;
      mem_write_enable = 1'b0;
      mem_addr         = '0;
      mem_write_data   = '0;
      busy             = 1'b0;
      done             = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = (effective_count != '0) ? WRITE_PREV : DONE;
            end
         end
         WRITE_PREV: begin
            mem_write_enable = 1'b1;
            busy             = 1'b1;
            mem_addr         = prev_addr;
            mem_write_data   = MDATA_WIDTH'(prev_sel);
            if (mem_write_ready) begin
               next_state = WRITE_DIST;
            end
         end
         WRITE_DIST: begin
            mem_write_enable = 1'b1;
            busy             = 1'b1;
            mem_addr         = prev_addr + MADDR_WIDTH'(1);
            mem_write_data   = MDATA_WIDTH'(dist_sel);
            if (mem_write_ready) begin
               next_state = last_node ? DONE : WRITE_PREV;
            end
         end
         DONE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

endmodule

// File: tb/tb_path_writeback.sv
// tb_path_writeback: table-driven and randomized checks of path_writeback against
// an abstract list-of-writes model built from N, base and the result vectors.
module tb_path_writeback;

   localparam int MAXN = 4;
   localparam int IW   = 4;
   localparam int VW   = 8;
   localparam int MA   = 10;
   localparam int MD   = 12;

   logic              clock = 1'b0;
   logic              reset;
   logic              start;
   logic [IW-1:0]     number_of_nodes;
   logic [MA-1:0]     base_address;
   logic [IW*MAXN-1:0] prev_vector_flattened;
   logic [VW*MAXN-1:0] distance_vector_flattened;
   logic              mem_write_enable;
   logic              mem_write_ready;
   logic [MA-1:0]     mem_addr;
   logic [MD-1:0]     mem_write_data;
   logic              busy;
   logic              done;

   logic [IW-1:0]     prevArr [MAXN];
   logic [VW-1:0]     distArr [MAXN];

   int checks = 0;
   int errors = 0;

   typedef struct {
      int addr;
      int data;
   } write_t;

   typedef struct {
      int nodes;
      int base;
      int readyPeriod;
      int restartAt;
      bit specVectors;
      int expWrites;
      int expDoneCycle;
   } vector_t;

   write_t  expQ[$];
   vector_t vectors[5];

   for (genvar j = 0; j < MAXN; j++) begin : g_flat
      assign prev_vector_flattened[IW*j +: IW]     = prevArr[j];
      assign distance_vector_flattened[VW*j +: VW] = distArr[j];
   end

   path_writeback #(
      .MAX_NODES  (MAXN),
      .INDEX_WIDTH(IW),
      .VALUE_WIDTH(VW),
      .MADDR_WIDTH(MA),
      .MDATA_WIDTH(MD)
   ) dut (
      .clock                    (clock),
      .reset                    (reset),
      .start                    (start),
      .number_of_nodes          (number_of_nodes),
      .base_address             (base_address),
      .prev_vector_flattened    (prev_vector_flattened),
      .distance_vector_flattened(distance_vector_flattened),
      .mem_write_enable         (mem_write_enable),
      .mem_write_ready          (mem_write_ready),
      .mem_addr                 (mem_addr),
      .mem_write_data           (mem_write_data),
      .busy                     (busy),
      .done                     (done)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // Expected writes: for each of min(N, MAXN) nodes, prev then distance, addresses mod 2^MA.
   task automatic buildModel(input int nodes, input int base);
      int n;
      expQ.delete();
      n = (nodes < MAXN) ? nodes : MAXN;
      for (int j = 0; j < n; j++) begin
         expQ.push_back('{(base + 2*j) % (1 << MA), int'(prevArr[j])});
         expQ.push_back('{(base + 2*j + 1) % (1 << MA), int'(distArr[j])});
      end
   endtask

   task automatic setSpecVectors();
      prevArr[0] = 0; prevArr[1] = 0; prevArr[2] = 1; prevArr[3] = 3;
      distArr[0] = 0; distArr[1] = 5; distArr[2] = 7; distArr[3] = 9;
   endtask

   task automatic setRandomVectors();
      for (int j = 0; j < MAXN; j++) begin
         prevArr[j] = IW'($urandom);
         distArr[j] = VW'($urandom);
      end
   endtask

   task automatic applyStimulus(input int nodes, input int base, input int readyPeriod,
                                input int restartAt, input int expWrites,
                                input int expDoneCycle, input string tag);
      int cyc;
      int accepted;
      int doneCycle;
      int heldAddr;
      int heldData;
      bit pending;
      bit rdy;
      buildModel(nodes, base);
      number_of_nodes = IW'(nodes);
      base_address    = MA'(base);
      mem_write_ready = 1'b0;
      start           = 1'b1;
      @(negedge clock);
      start           = 1'b0;
      number_of_nodes = IW'($urandom);
      base_address    = MA'($urandom);
      cyc       = 0;
      accepted  = 0;
      doneCycle = -1;
      pending   = 1'b0;
      heldAddr  = 0;
      heldData  = 0;
      while (cyc < 200) begin
         rdy             = ((cyc % readyPeriod) == readyPeriod - 1);
         mem_write_ready = rdy;
         start           = (cyc == restartAt);
         if (done) begin
            doneCycle = cyc;
            break;
         end
         if (mem_write_enable) begin
            if (accepted >= expQ.size()) begin
               checkOutput({tag, " extraWrite"}, accepted, expQ.size() + 1);
               break;
            end
            checkOutput({tag, " busyWhileWriting"}, busy, 1);
            if (pending) begin
               checkOutput({tag, " holdAddr"}, mem_addr, heldAddr);
               checkOutput({tag, " holdData"}, mem_write_data, heldData);
            end
            if (rdy) begin
               checkOutput({tag, " addr"}, mem_addr, expQ[accepted].addr);
               checkOutput({tag, " data"}, mem_write_data, expQ[accepted].data);
               accepted++;
               pending = 1'b0;
            end else begin
               pending  = 1'b1;
               heldAddr = int'(mem_addr);
               heldData = int'(mem_write_data);
            end
         end else if (accepted < expQ.size()) begin
            checkOutput({tag, " enableLowEarly"}, mem_write_enable, 1);
            break;
         end
         @(negedge clock);
         cyc++;
      end
      start = 1'b0;
      checkOutput({tag, " accepts"}, accepted, (expWrites >= 0) ? expWrites : expQ.size());
      checkOutput({tag, " doneSeen"}, (doneCycle >= 0), 1);
      if (doneCycle >= 0) begin
         checkOutput({tag, " enableInDone"}, mem_write_enable, 0);
         checkOutput({tag, " busyInDone"}, busy, 0);
         if (expDoneCycle >= 0) begin
            checkOutput({tag, " doneCycle"}, doneCycle, expDoneCycle);
         end
      end
      mem_write_ready = 1'b0;
      @(negedge clock);
      checkOutput({tag, " donePulseOnce"}, done, 0);
      checkOutput({tag, " idleEnable"}, mem_write_enable, 0);
      checkOutput({tag, " idleBusy"}, busy, 0);
   endtask

   initial begin
      int n;
      int p;
      vectors[0] = '{3, 'h100, 1, -1, 1'b1, 6, 6};
      vectors[1] = '{3, 'h100, 3, -1, 1'b1, 6, -1};
      vectors[2] = '{0, 'h055, 1, -1, 1'b1, 0, 0};
      vectors[3] = '{2, (1 << MA) - 2, 1, -1, 1'b1, 4, 4};
      vectors[4] = '{MAXN + 1, 'h020, 1, 2, 1'b0, 2*MAXN, 2*MAXN};

      reset           = 1'b1;
      start           = 1'b0;
      mem_write_ready = 1'b0;
      number_of_nodes = '0;
      base_address    = '0;
      setSpecVectors();
      repeat (2) @(negedge clock);
      checkOutput("reset enable", mem_write_enable, 0);
      checkOutput("reset addr", mem_addr, 0);
      checkOutput("reset data", mem_write_data, 0);
      checkOutput("reset busy", busy, 0);
      checkOutput("reset done", done, 0);
      reset = 1'b0;
      @(negedge clock);

      for (int v = 0; v < 5; v++) begin
         if (vectors[v].specVectors) setSpecVectors();
         else setRandomVectors();
         applyStimulus(vectors[v].nodes, vectors[v].base, vectors[v].readyPeriod,
                       vectors[v].restartAt, vectors[v].expWrites,
                       vectors[v].expDoneCycle, $sformatf("vec%0d", v));
      end

      // Reset during the third write of an N=3 run abandons it without a done pulse.
      setSpecVectors();
      number_of_nodes = 3;
      base_address    = 'h100;
      mem_write_ready = 1'b1;
      start           = 1'b1;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      @(negedge clock);
      checkOutput("midReset thirdAddr", mem_addr, 'h102);
      checkOutput("midReset thirdEnable", mem_write_enable, 1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      checkOutput("midReset enable", mem_write_enable, 0);
      checkOutput("midReset addr", mem_addr, 0);
      checkOutput("midReset data", mem_write_data, 0);
      checkOutput("midReset busy", busy, 0);
      checkOutput("midReset done", done, 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         checkOutput("midReset noDone", done, 0);
         checkOutput("midReset noEnable", mem_write_enable, 0);
      end
      applyStimulus(3, 'h100, 1, -1, 6, 6, "afterReset");

      for (int r = 0; r < 20; r++) begin
         setRandomVectors();
         n = $urandom_range(0, MAXN + 2);
         p = $urandom_range(1, 3);
         applyStimulus(n, $urandom_range(0, (1 << MA) - 1), p, $urandom_range(0, 4), -1,
                       (p == 1) ? 2 * ((n < MAXN) ? n : MAXN) : -1,
                       $sformatf("rand%0d", r));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
